// File: rtl/mcu_pkg.sv
// Shared types and codes for the multicycle main control FSM.
// The ALU control unit imports the ALUOp codes from here.
package mcu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mcu_output_decoder.sv
// Combinational state -> control word decode for the main FSM.
// Only FETCH looks at mem_ready, to gate the IR/PC write.
module mcu_output_decoder
  import mcu_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main multicycle control FSM with retire counter.
// Define MCU_ILLEGAL_TRAP_EN to trap illegal opcodes (adds `illegal`).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
`ifdef MCU_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t     st;
  state_t     st_nx;
  logic [5:0] op_q;
  logic       retire;
  ctrl_t      dec;
  ctrl_t      ctrl;

  always_comb begin
    st_nx  = st;
    retire = 1'b0;
    case (st)
      S_FETCH:
        if (mem_ready) st_nx = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: st_nx = S_MEMADR;
          OP_RTYPE:     st_nx = S_EXEC;
          OP_BEQ:       st_nx = S_BRANCH;
          OP_J:         st_nx = S_JUMP;
          OP_ADDI:      st_nx = S_ADDIEX;
          default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
            st_nx = S_TRAP;
`else
            st_nx  = S_FETCH;
            retire = 1'b1;
`endif
          end
        endcase
      S_MEMADR:
        st_nx = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:
        if (mem_ready) st_nx = S_MEMWB;
      S_MEMWR:
        if (mem_ready) begin
          st_nx  = S_FETCH;
          retire = 1'b1;
        end
      S_EXEC:   st_nx = S_ALUWB;
      S_ADDIEX: st_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        st_nx  = S_FETCH;
        retire = 1'b1;
      end
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP: st_nx = S_TRAP;
`endif
      default: st_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_FETCH;
      op_q        <= '0;
      instr_count <= '0;
`ifdef MCU_ILLEGAL_TRAP_EN
      illegal     <= 1'b0;
`endif
    end else begin
      st <= st_nx;
      if (st == S_DECODE) op_q <= opcode;
      if (retire) instr_count <= instr_count + CNT_W'(1);
`ifdef MCU_ILLEGAL_TRAP_EN
      if (st_nx == S_TRAP) illegal <= 1'b1;
`endif
    end
  end

  mcu_output_decoder u_dec (
    .state     (st),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Reset forces every strobe and select low, even mid-instruction.
  assign ctrl = rst ? '0 : dec;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ior_d         = ctrl.ior_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign state         = st;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (CNT_W=4 for wrap).
// Honours MCU_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ready = 1'b1;
  logic          pc_write, pc_write_cond, ior_d, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0]    alu_src_b, pc_source, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic          illegal;
`endif

  int n_vec = 0;
  int n_bad = 0;

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ior_d         (ior_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .state         (state),
    .instr_count   (instr_count)
`ifdef MCU_ILLEGAL_TRAP_EN
    ,
    .illegal       (illegal)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] JJ = 6'b000010, AI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  function automatic logic [15:0] dv();
    return {pc_write, pc_write_cond, ior_d, mem_read, mem_write,
            ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
            alu_src_b, pc_source, alu_op};
  endfunction

  // Control word each state must show, written from the state table.
  function automatic logic [15:0] exp_ctrl(int s, logic mr, logic r);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rw, rd, sa;
    logic [1:0] sb, ps, ao;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rw, rd, sa} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      0: begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
      1: sb = 2'b11;
      2, 10: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin pw = 1; ps = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (r) return 16'h0000;
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, sb, ps, ao};
  endfunction

  // Model: each instruction is a queue of states still to visit.
  int            m_st = 0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_ill = 1'b0;
  logic          armed = 1'b0;
  int            q[$];

  task automatic step();
    if (rst) begin
      m_st = 0; m_cnt = '0; m_ill = 1'b0; armed = 1'b1;
      q.delete();
    end else if (armed && m_st != 12) begin
      if ((m_st == 0 || m_st == 3 || m_st == 5) && !mem_ready) begin
      end else begin
        if (m_st == 0) q = {1};
        else if (m_st == 1) begin
          if (opcode == LW) q = {2, 3, 4};
          else if (opcode == SW) q = {2, 5};
          else if (opcode == RT) q = {6, 7};
          else if (opcode == BQ) q = {8};
          else if (opcode == JJ) q = {9};
          else if (opcode == AI) q = {10, 11};
`ifdef MCU_ILLEGAL_TRAP_EN
          else q = {12};
`else
          else q.delete();
`endif
        end
        if (q.size() == 0) begin
          m_st = 0;
          m_cnt = m_cnt + 1'b1;
        end else begin
          m_st = q.pop_front();
          if (m_st == 12) m_ill = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    step();
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (armed) begin
      logic ok;
      ok = (dv() == exp_ctrl(m_st, mem_ready, rst)) &&
           (int'(state) == m_st) && (instr_count == m_cnt);
`ifdef MCU_ILLEGAL_TRAP_EN
      ok = ok && (illegal == m_ill);
`endif
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL cycle @%0t: ctrl %h exp %h state %0d exp %0d cnt %0d exp %0d",
                 $time, dv(), exp_ctrl(m_st, mem_ready, rst),
                 state, m_st, instr_count, m_cnt);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input logic mr);
    @(negedge clk);
    rst = r; opcode = op; mem_ready = mr;
    #2;
  endtask

  logic [5:0] ops[6] = '{RT, LW, SW, BQ, JJ, AI};

  initial begin
    cyc(1, RT, 1);
    cyc(1, RT, 1);
    lit("rst_state", int'(state), 0);
    lit("rst_cnt", int'(instr_count), 0);
    lit("rst_ctrl", int'(dv()), 0);
    // R-type: 0,1,6,7,0
    cyc(0, RT, 1); lit("r_fetch_wr", int'({ir_write, pc_write}), 3);
    cyc(0, RT, 1); lit("r_dec", int'(state), 1);
    cyc(0, RT, 1); lit("r_exec", int'(state), 6);
    lit("r_aluop", int'(alu_op), 2);
    cyc(0, RT, 1); lit("r_wb", int'({state, reg_dst, reg_write}), 7*4+3);
    cyc(0, LW, 1); lit("r_cnt", int'(instr_count), 1);
    // lw with two MEMRD waits; opcode changes after DECODE
    cyc(0, LW, 1); lit("lw_dec", int'(state), 1);
    cyc(0, SW, 1); lit("lw_adr", int'(state), 2);
    cyc(0, SW, 0); lit("lw_rd0", int'(state), 3);
    cyc(0, SW, 0); lit("lw_rd1", int'(state), 3);
    cyc(0, SW, 1); lit("lw_rd2", int'(state), 3);
    cyc(0, SW, 1); lit("lw_wb", int'({state, mem_to_reg}), 4*2+1);
    cyc(0, BQ, 1); lit("lw_cnt", int'(instr_count), 2);
    // beq then j
    cyc(0, BQ, 1);
    cyc(0, BQ, 1); lit("beq_st", int'(state), 8);
    lit("beq_ctl", int'({alu_op, pc_write_cond, pc_source}), 5'b01101);
    cyc(0, JJ, 1); lit("beq_cnt", int'(instr_count), 3);
    cyc(0, JJ, 1);
    cyc(0, JJ, 1); lit("j_st", int'(state), 9);
    lit("j_ctl", int'({pc_write, pc_source}), 3'b110);
    cyc(0, BAD, 1); lit("j_cnt", int'(instr_count), 4);
    cyc(0, BAD, 1); lit("bad_dec", int'(state), 1);
`ifdef MCU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cyc(0, RT, 1);
      lit("trap_st", int'(state), 12);
      lit("trap_ctl", int'(dv()), 0);
      lit("trap_ill", int'(illegal), 1);
      lit("trap_cnt", int'(instr_count), 4);
    end
`else
    cyc(0, RT, 1);
    lit("nop_st", int'(state), 0);
    lit("nop_cnt", int'(instr_count), 5);
`endif
    // reset in MEMRD
    cyc(1, LW, 1);
    cyc(0, LW, 1);
    cyc(0, LW, 1);
    cyc(0, LW, 1);
    cyc(0, LW, 0); lit("mid_rd", int'(state), 3);
    cyc(1, LW, 1); lit("mid_rst_ctl", int'(dv()), 0);
    cyc(0, JJ, 1); lit("mid_st", int'(state), 0);
    lit("mid_cnt", int'(instr_count), 0);
    // counter wrap on the 16th retire
    for (int i = 0; i < 15; i++) begin
      cyc(0, JJ, 1);
      cyc(0, JJ, 1);
      cyc(0, JJ, 1);
    end
    lit("wrap15", int'(instr_count), 15);
    cyc(0, JJ, 1);
    cyc(0, JJ, 1);
    cyc(0, JJ, 1); lit("wrap16", int'(instr_count), 0);
    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic r, mr;
      logic [5:0] op;
      int k;
      r = ($urandom_range(0, 59) == 0);
      k = $urandom_range(0, 7);
      op = (k < 6) ? ops[k] : 6'($urandom);
      mr = ($urandom_range(0, 3) != 0);
      cyc(r, op, mr);
    end
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
